// File: rtl/clk_tick_pkg.sv
// Shared definitions for the programmable tick generator family.
// State encoding and mode constants are common to single- and multi-channel blocks.
package clk_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tick_state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/clk_tick_period_reg.sv
// Period register with a shadow copy so runtime reloads take effect only at a
// period boundary (or immediately when the counter is not running).
module clk_tick_period_reg #(
    parameter int unsigned BIT_SZ         = 16,
    parameter int unsigned DEFAULT_PERIOD = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              running,
    input  logic              boundary,
    input  logic              period_load,
    input  logic [BIT_SZ-1:0] period_in,
    output logic [BIT_SZ-1:0] period_reg,
    output logic              period_pending
);

    logic [BIT_SZ-1:0] period_q, period_d;
    logic [BIT_SZ-1:0] shadow_q, shadow_d;
    logic              pending_q, pending_d;

    always_comb begin
        period_d  = period_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (period_load) begin
            // A load on the boundary cycle governs the very next period directly.
            if (!running || boundary) begin
                period_d  = period_in;
                pending_d = 1'b0;
            end else begin
                shadow_d  = period_in;
                pending_d = 1'b1;
            end
        end else if (boundary && pending_q) begin
            period_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_q  <= BIT_SZ'(DEFAULT_PERIOD);
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign period_reg     = period_q;
    assign period_pending = pending_q;

endmodule

// File: rtl/clk_tick_prog.sv
// Runtime-programmable tick generator: one-cycle tick every (period+1) enabled
// cycles, with continuous/one-shot modes, start/restart and a wrapping tick counter.
module clk_tick_prog
    import clk_tick_pkg::*;
#(
    parameter int unsigned BIT_SZ         = 16,
    parameter int unsigned CNT_SZ         = 16,
    parameter int unsigned DEFAULT_PERIOD = 500,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              mode,
    input  logic [BIT_SZ-1:0] period_in,
    input  logic              period_load,
    output logic              tick,
    output logic [CNT_SZ-1:0] tick_count,
    output logic [BIT_SZ-1:0] count,
    output logic              running,
    output logic              period_pending
);

    tick_state_t       state_q, state_d;
    logic [BIT_SZ-1:0] count_q, count_d;
    logic [CNT_SZ-1:0] tick_count_q, tick_count_d;
    logic              tick_q, tick_d;
    logic [BIT_SZ-1:0] period_reg;
    logic              tc;

    assign tc = (state_q == RUN) && enable && (count_q == period_reg);

    clk_tick_period_reg #(
        .BIT_SZ         (BIT_SZ),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_period_reg (
        .clock          (clock),
        .reset          (reset),
        .running        (state_q == RUN),
        .boundary       (tc),
        .period_load    (period_load),
        .period_in      (period_in),
        .period_reg     (period_reg),
        .period_pending (period_pending)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tick_count_d = tick_count_q;
        tick_d       = 1'b0;
        // start wins over a coinciding terminal count and ignores enable.
        if (start) begin
            state_d = RUN;
            count_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (tc) begin
                            tick_d       = 1'b1;
                            count_d      = '0;
                            tick_count_d = tick_count_q + CNT_SZ'(1);
                            if (mode == MODE_ONESHOT) begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + BIT_SZ'(1);
                        end
                    end
                end
                IDLE, DONE: count_d = '0;
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= AUTO_START ? RUN : IDLE;
            count_q      <= '0;
            tick_count_q <= '0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tick_count_q <= tick_count_d;
            tick_q       <= tick_d;
        end
    end

    assign tick       = tick_q;
    assign tick_count = tick_count_q;
    assign count      = count_q;
    assign running    = (state_q == RUN);

endmodule

// File: doc/clk_tick_prog.md
Name: clk_tick_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed divide-by-501 tick generator.
- Emits a one-cycle tick every (period+1) enabled clock cycles.
- Period is loadable at runtime through a shadow register, so changes apply glitch-free at the period boundary.
- Supports continuous and one-shot modes, plus start, pause and a wrapping tick counter.
- Feeds display-scan, debounce and sampling logic in the ex8-style timing datapath.

Parameters:
- BIT_SZ, 16: width of the period and the cycle counter.
- CNT_SZ, 16: width of tick_count.
- DEFAULT_PERIOD, 500: period_reg value after reset. Must fit in BIT_SZ.
- AUTO_START, 1: if 1, enter RUN on reset release; if 0, enter IDLE.

Ports:
- clock, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: count qualifier; when low, state is frozen and tick is held low.
- start, input, 1: pulse. Starts from IDLE/DONE; restarts the period in RUN.
- mode, input, 1: 0 = continuous, 1 = one-shot. Sampled at start and at each terminal count.
- period_in, input, BIT_SZ: new period value.
- period_load, input, 1: pulse; captures period_in.
- tick, output, 1: one-cycle pulse at terminal count.
- tick_count, output, CNT_SZ: number of ticks since reset; wraps modulo 2^CNT_SZ.
- count, output, BIT_SZ: current cycle counter.
- running, output, 1: high in RUN.
- period_pending, output, 1: shadow holds a value that has not yet been applied.

Behaviour:
- Clocking and reset:
  - Single clock domain. Synchronous active-high reset on posedge clock; reset has priority over all inputs.
  - Reset values: count=0, tick=0, tick_count=0, period_reg=DEFAULT_PERIOD, shadow=0, period_pending=0.
  - Reset state is RUN (running=1) if AUTO_START=1, otherwise IDLE (running=0).
  - Reset asserted mid-period abandons the period with no tick; it is identical to a power-up reset.
- States:
  - IDLE: count held at 0, tick=0.
  - RUN: counting.
  - DONE: reached after a one-shot tick; count=0, tick=0.
- Terminal count (TC): state==RUN && enable && count==period_reg.
- RUN with enable=1:
  - On TC: tick=1, count=0, tick_count+=1.
  - Otherwise: count+=1, tick=0.
  - A tick is registered, asserting on the clock edge where count wraps to 0.
  - Tick spacing is period_reg+1 enabled cycles; period_reg=0 ticks on every enabled cycle.
- RUN with enable=0: count, state and tick_count are held; tick=0. Tick is never stretched across disabled cycles.
- On TC, mode is sampled:
  - mode=1: next state DONE.
  - mode=0: stay in RUN.
- start:
  - In IDLE/DONE: next state RUN, count=0. The first tick follows period_reg+1 enabled cycles later.
  - In RUN: count=0, no tick that cycle.
  - start has priority over a coinciding TC: that tick is suppressed and tick_count is not incremented.
  - start is honoured regardless of enable.
- period_load:
  - In IDLE/DONE: period_reg=period_in immediately; period_pending stays 0.
  - In RUN without TC: shadow=period_in, period_pending=1. A later load before TC overwrites the shadow; last value wins.
  - In RUN on a TC cycle: period_reg=period_in directly, which governs the next period; any prior shadow is discarded and period_pending=0.
  - On TC with period_pending=1: period_reg=shadow, period_pending=0.
  - Loading a period_in smaller than the current count has no effect until the boundary; the current period always completes with its old value.
- Width rules:
  - count and tick_count are unsigned and wrap silently.
  - count never exceeds period_reg, because period_reg only changes at a boundary or when not running.

Decomposition:
- Shared package clk_tick_pkg:
  - State encoding: typedef enum {IDLE, RUN, DONE}, 2 bits.
  - Mode constants MODE_CONT=1'b0 and MODE_ONESHOT=1'b1.
  - Reused by future multi-channel tick blocks.
- Sub-module clk_tick_period_reg: shadow register, pending flag and apply-at-boundary logic. Instantiated once here and reusable.
- FSM, counter and tick logic stay in the top level.

Test Plan:
- Reset default: reset 2 cycles, AUTO_START=1, enable=1 → first tick after 501 cycles, then every 501 cycles; tick_count=3 after 1503 cycles.
- Gated enable: period 3, enable toggling 1,0,1,0... → tick every 4 enabled cycles (8 clocks); tick=0 and count frozen on every disabled cycle.
- Shadow load: period 9 in RUN, count=4, load 2 → period_pending=1 and the current period completes with tick at count 9; the following ticks are 3 cycles apart and period_pending=0.
- Load at TC: load 5 on the exact TC cycle → the next tick comes 6 cycles later, period_pending stays 0.
- One-shot: IDLE, mode=1, period 4, start → exactly one tick 5 cycles later, then DONE with running=0; a second start gives one more tick, tick_count=2.
- Collisions and reset: start coinciding with TC → no tick and count=0. Reset asserted at count=7 of period 9 → count=0, tick_count=0, period_reg=500, period_pending=0.
